// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the ALU issue controller.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;
  localparam logic [2:0] OP_ONES = 3'd6;
  localparam logic [2:0] OP_ABS  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two asynchronous read ports, one synchronous write port,
// synchronous active-low clear of every entry.
module alu_regfile
  import alu_ctrl_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int REGS = 4,
  localparam int RA   = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [RA-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [RA-1:0] raddr1,
  input  logic [RA-1:0] raddr2,
  output logic [N-1:0]  rdata1,
  output logic [N-1:0]  rdata2
);

  logic [N-1:0] mem [REGS];

  // NOTE: every entry is cleared by reset, so this stays flops rather than a RAM macro;
  // state is written with non-blocking assignments so all entries update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Serialised issue controller for the external combinational ALU: accepts an instruction,
// registers operands for one EXEC cycle, writes the result back and returns a completion.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int REGS = 4,
  localparam int RA   = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          instr_load,
  input  logic [2:0]    instr_opcode,
  input  logic [RA-1:0] instr_rd,
  input  logic [RA-1:0] instr_rs1,
  input  logic [RA-1:0] instr_rs2,
  input  logic [N-1:0]  instr_imm,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [2:0]    alu_opcode,
  input  logic [N-1:0]  alu_result,
  input  logic [1:0]    alu_flags,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_data,
  output logic [1:0]    res_flags,
  output logic [RA-1:0] res_rd
);

  state_t        state, state_next;
  logic          accept;
  logic [RA-1:0] rd_q;
  logic          rf_we;
  logic [RA-1:0] rf_waddr;
  logic [N-1:0]  rf_wdata;
  logic [N-1:0]  rf_rdata1, rf_rdata2;
  logic [1:0]    load_flags;

  alu_regfile #(.N(N), .REGS(REGS)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr1 (instr_rs1),
    .raddr2 (instr_rs2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: combinational blocks assign a default to every output first, so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = instr_load ? ST_RESP : ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (res_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    res_valid   = 1'b0;
    case (state)
      ST_IDLE: instr_ready = rst_n;
      ST_RESP: res_valid   = 1'b1;
      default: ;
    endcase
  end

  assign accept = instr_valid & instr_ready;

  // Loads write at acceptance; ALU ops write at the end of their single EXEC cycle.
  always_comb begin
    rf_we                 = 1'b0;
    rf_waddr              = rd_q;
    rf_wdata              = alu_result;
    load_flags            = '0;
    load_flags[FLAG_ZERO] = (instr_imm == '0);
    if (state == ST_EXEC) begin
      rf_we = 1'b1;
    end else if (accept && instr_load) begin
      rf_we    = 1'b1;
      rf_waddr = instr_rd;
      rf_wdata = instr_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rd_q       <= '0;
      res_data   <= '0;
      res_flags  <= '0;
      res_rd     <= '0;
    end else begin
      if (accept) begin
        if (instr_load) begin
          res_data  <= instr_imm;
          res_flags <= load_flags;
          res_rd    <= instr_rd;
        end else begin
          alu_a      <= rf_rdata1;
          alu_b      <= rf_rdata2;
          alu_opcode <= instr_opcode;
          rd_q       <= instr_rd;
        end
      end
      if (state == ST_EXEC) begin
        res_data  <= alu_result;
        res_flags <= alu_flags;
        res_rd    <= rd_q;
      end
    end
  end

endmodule
